// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register file slice.
//   REG_ADDR_W : architectural register address width
//   ZERO_REG   : index of the hardwired-zero register
//   reg_addr_t : register address type
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/Mux2.sv
// Mux2: two-input word multiplexer shared by the datapath.
//   d0, d1 : data inputs (width bits)
//   s      : select, 1 picks d1
//   y      : selected word
module Mux2 #(
    parameter int width = 32
) (
    input  logic [width-1:0] d0,
    input  logic [width-1:0] d1,
    input  logic             s,
    output logic [width-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write tracker for the register file.
//   clk, rst_n           : clock, synchronous active-low reset
//   rs1, rs2             : operand addresses to query
//   rs1_busy, rs2_busy   : operand still waiting on a reserved write
//   we, wa               : write-back strobe and address (releases reservations)
//   issue_valid,issue_rd : reservation request and destination
//   issue_ready          : the reservation would be accepted this cycle
//   pending_cnt          : number of currently reserved registers
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter  int nregs = 32,
    localparam int aw    = $clog2(nregs)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [aw-1:0] rs1,
    input  logic [aw-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy,
    input  logic          we,
    input  logic [aw-1:0] wa,
    input  logic          issue_valid,
    input  logic [aw-1:0] issue_rd,
    output logic          issue_ready,
    output logic [aw:0]   pending_cnt
);

    localparam logic [aw-1:0] ZERO = aw'(ZERO_REG);

    logic [nregs-1:0] busy_q;
    logic [nregs-1:0] busy_d;
    logic [aw:0]      cnt_q;

    logic wr_hits_issue;
    logic issue_acc;
    logic wr_clr;
    logic cnt_inc;
    logic cnt_dec;

    always_comb begin
        wr_hits_issue = we && (wa == issue_rd);
        issue_ready   = (issue_rd == ZERO) || !busy_q[issue_rd] || wr_hits_issue;
        issue_acc     = issue_valid && issue_ready && (issue_rd != ZERO);
        wr_clr        = we && (wa != ZERO) && busy_q[wa];
        cnt_inc       = issue_acc && !busy_q[issue_rd];
        // A write releasing the very register being re-reserved hands the
        // bit straight to the new producer, so the count must not drop.
        cnt_dec       = wr_clr && !(issue_acc && wr_hits_issue);

        busy_d = busy_q;
        if (wr_clr)
            busy_d[wa] = 1'b0;
        // Applied after the clear so a same-register collision keeps the bit.
        if (issue_acc)
            busy_d[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (cnt_inc && !cnt_dec)
                cnt_q <= cnt_q + (aw+1)'(1);
            else if (cnt_dec && !cnt_inc)
                cnt_q <= cnt_q - (aw+1)'(1);
        end
    end

    // A write landing this cycle already feeds the operand via the bypass.
    assign rs1_busy    = busy_q[rs1] && !(we && (wa == rs1));
    assign rs2_busy    = busy_q[rs2] && !(we && (wa == rs2));
    assign pending_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read, one-write register file with write-through bypass
// and an integrated pending-write scoreboard. Register 0 reads as zero.
//   clk, rst_n           : clock, synchronous active-low reset (clears all)
//   rs1, rs2 / rd1, rd2  : read addresses / combinational read data
//   rs1_busy, rs2_busy   : operand has an outstanding reserved write
//   we, wa, wd           : write-back strobe, address, data
//   issue_valid,issue_rd : reserve a destination for a multicycle producer
//   issue_ready          : reservation would be accepted this cycle
//   pending_cnt          : number of reserved registers
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int width = 32,
    parameter  int nregs = 32,
    localparam int aw    = $clog2(nregs)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [aw-1:0]    rs1,
    input  logic [aw-1:0]    rs2,
    output logic [width-1:0] rd1,
    output logic [width-1:0] rd2,
    output logic             rs1_busy,
    output logic             rs2_busy,
    input  logic             we,
    input  logic [aw-1:0]    wa,
    input  logic [width-1:0] wd,
    input  logic             issue_valid,
    input  logic [aw-1:0]    issue_rd,
    output logic             issue_ready,
    output logic [aw:0]      pending_cnt
);

    localparam logic [aw-1:0] ZERO = aw'(ZERO_REG);

    logic [width-1:0] regs [nregs];
    logic [width-1:0] raw1;
    logic [width-1:0] raw2;
    logic             byp1;
    logic             byp2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < nregs; i++)
                regs[i] <= '0;
        end else if (we && (wa != ZERO)) begin
            regs[wa] <= wd;
        end
    end

    // Register 0 is forced to zero on the read side, so its storage never matters.
    always_comb begin
        raw1 = (rs1 == ZERO) ? '0 : regs[rs1];
        raw2 = (rs2 == ZERO) ? '0 : regs[rs2];
        byp1 = we && (wa == rs1) && (wa != ZERO);
        byp2 = we && (wa == rs2) && (wa != ZERO);
    end

    Mux2 #(.width(width)) u_byp1 (
        .d0 (raw1),
        .d1 (wd),
        .s  (byp1),
        .y  (rd1)
    );

    Mux2 #(.width(width)) u_byp2 (
        .d0 (raw2),
        .d1 (wd),
        .s  (byp2),
        .y  (rd2)
    );

    reg_scoreboard #(.nregs(nregs)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .we          (we),
        .wa          (wa),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Register file with an integrated pending-write scoreboard. It sits directly downstream of the write-back `Mux4`: the selected write-back word arrives on `wd`. Two operand words go out to the ALU-input `Mux2` and `Mux4` stages. Multicycle producers reserve a destination at issue, and the block reports busy operands so the control FSM can stall.

## Interface
Parameters:
- `width`, 32, data word width
- `nregs`, 32, number of architectural registers (power of two; address width `aw = $clog2(nregs)`)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`
- `rs1`, `rs2`  in  aw  read addresses
- `rd1`, `rd2`  out  width  read data (combinational)
- `rs1_busy`, `rs2_busy`  out  1  operand has an outstanding reserved write
- `we`  in  1  write enable from write-back stage
- `wa`  in  aw  write address
- `wd`  in  width  write data (write-back mux output)
- `issue_valid`  in  1  request to reserve `issue_rd`
- `issue_rd`  in  aw  destination to reserve
- `issue_ready`  out  1  reservation would be accepted this cycle
- `pending_cnt`  out  aw+1  number of reserved registers

## Operation
- Register 0 is hardwired to zero:
  - never written, never reserved
  - reads return 0 and are never busy
- Read: `rdN = regs[rsN]`, with write-through bypass:
  - if `we && wa == rsN && wa != 0`, then `rdN = wd`.
- Write: on an edge with `rst_n = 1`, `we = 1` and `wa != 0`, set `regs[wa] <= wd`.
  - Writing a non-reserved register is legal (single-cycle producers) and leaves the scoreboard unchanged.
- Scoreboard `busy[nregs-1:0]`:
  - Accepted issue (`issue_valid && issue_ready && issue_rd != 0`) sets `busy[issue_rd]`.
  - A write to a busy register clears its bit.
  - Same-edge issue and write to the same nonzero register: the set wins. The bit stays 1; this is the new producer.
- `rsN_busy = busy[rsN] && !(we && wa == rsN)`: a write arriving this cycle releases the operand through the bypass.
- `issue_ready = !busy[issue_rd] || (we && wa == issue_rd)`. It is always 1 for `issue_rd = 0`.
  - An issue with `issue_ready = 0` is ignored: no state change. The FSM must hold the request.
  - An issue to register 0 is accepted with no effect.
- `pending_cnt` equals popcount(`busy`) at all times:
  - +1 on an accepted issue to a non-busy nonzero register
  - −1 on a write that clears a bit
  - unchanged when both occur on the same register, or when a +1 and a −1 on different registers coincide
- Saturation is impossible: at most `nregs-1` registers can be reserved.

## Timing
- Reset: on an edge with `rst_n = 0`, all `regs` = 0, `busy` = 0 and `pending_cnt` = 0.
  - Following that edge: `rd1 = rd2 = 0` (no write) and `rs*_busy = 0`.
  - `issue_ready = 1`.
- Reset has priority over a simultaneous write or issue: both are dropped. In-flight reservations are discarded.
- Read latency is 0 cycles (combinational, including the bypass).
- A write at edge N is visible from `regs` after edge N. During the cycle before edge N it is already visible through the bypass.
- A reservation at edge N makes `rsN_busy` high from just after edge N until the write cycle.

## Structure
- Shared package `rf_pkg`:
  - `REG_ADDR_W = 5`
  - `ZERO_REG = 0`
  - `reg_addr_t` typedef
- Sub-module `reg_scoreboard` holds `busy`, `pending_cnt`, and the `issue_ready`/`rs*_busy` logic. Its parameter is `nregs`.
- The top level holds the storage array and the bypass muxes, built from the existing `Mux2` with `width`.

## Test plan
- **Reset:** write `regs[5]=0xDEAD`, then hold `rst_n=0` one edge.
  - Required: `rd1` for `rs1=5` is 0; `pending_cnt = 0`; `issue_ready = 1`.
- **x0 write:** `we=1`, `wa=0`, `wd=0xFFFF_FFFF`.
  - Required: `rs1=0` reads 0 both during that cycle and after the edge.
- **Bypass:** `we=1`, `wa=3`, `wd=0x1234`, `rs2=3` in the same cycle.
  - Required: `rd2 = 0x1234` before the edge and after it.
- **Reserve and release:** issue `rd=7`, then read `rs1=7`.
  - Required: `rs1_busy = 1` and `pending_cnt = 1`.
  - Then write `wa=7`, `wd=0xAB`. Required: `rs1_busy = 0` in that cycle, `rd1 = 0xAB`, and `pending_cnt = 0` after the edge.
- **WAW stall and collision:** with 7 reserved, issue 7 without a write.
  - Required: `issue_ready = 0`; no state change.
  - Then issue 7 together with `we`, `wa=7`. Required: accepted, `busy[7]` stays 1, `pending_cnt` stays 1.
- **Mixed edge:** issue 9 while writing reserved 7.
  - Required: `pending_cnt` unchanged at 1; `busy[9] = 1`; `busy[7] = 0`.
